// File: rtl/serial_twos_complementer.sv
// Bit-serial two's complementer: negates a WIDTH-bit operand LSB-first over WIDTH cycles.
// Optional overflow flag (most-negative operand) enabled by defining TWOS_COMP_OVF_EN.
module serial_twos_complementer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef TWOS_COMP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opnd_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  out_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic              last_bit;
  logic              sum_bit;
  logic [WIDTH-1:0]  res_shift;

  // Single full-adder stage: A = ~operand bit, B = 0, Cin = registered carry.
  assign sum_bit   = ~opnd_q[0] ^ carry_q;
  assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q  <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opnd_q  <= in_data;
            carry_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          opnd_q  <= opnd_q >> 1;
          res_q   <= res_shift;
          carry_q <= ~opnd_q[0] & carry_q;
          // Counter stops at WIDTH-1 so it never wraps; the full result is published here.
          if (last_bit) out_q <= res_shift;
          else          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_q;

`ifdef TWOS_COMP_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)                           ovf_q <= 1'b0;
    else if (state_q == IDLE && in_valid) ovf_q <= (in_data == {1'b1, {(WIDTH-1){1'b0}}});
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Self-checking bench for serial_twos_complementer: WIDTH=8 scenarios plus a WIDTH 2/16/33 sweep.
// Overflow checks are compiled in only when TWOS_COMP_OVF_EN is defined.
module tb_serial_twos_complementer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;
  bit sweep_start = 0;

  logic [7:0] exp_q[$];

  serial_twos_complementer #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef TWOS_COMP_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef TWOS_COMP_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand for one edge (block must be idle) and logs the expected negation.
  task automatic issue(input logic [7:0] x);
    logic [7:0] e;
    e = ~x + 8'd1;
    in_valid = 1'b1;
    in_data  = x;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from acceptance until out_valid, bounded by max.
  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (!out_valid && lat < max) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
`ifdef TWOS_COMP_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] e;
    issue(8'h05);
    wait_valid(40, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== 8) begin n_errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_checks++;
    if (out_data !== e || e !== 8'hFB) begin n_errors++; $display("FAIL basic_data: got %h expected %h", out_data, e); end
`ifdef TWOS_COMP_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL basic_one_cycle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== 8'hFB) begin n_errors++; $display("FAIL basic_hold: got %h expected fb", out_data); end
  endtask

  task automatic test_edge_values();
    logic [7:0] ins  [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    logic [7:0] outs [4] = '{8'h00, 8'h01, 8'h80, 8'h81};
    int lat;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ins[i]);
      wait_valid(40, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== outs[i] || e !== outs[i]) begin
        n_errors++; $display("FAIL edge_%h: got %h valid=%b expected %h", ins[i], out_data, out_valid, outs[i]);
      end
`ifdef TWOS_COMP_OVF_EN
      n_checks++;
      if (ovf !== (ins[i] == 8'h80)) begin n_errors++; $display("FAIL edge_ovf_%h: got %b expected %b", ins[i], ovf, ins[i] == 8'h80); end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] e;
    out_ready = 1'b0;
    issue(8'h05);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_shift: got %b expected 0", in_ready); end
    wait_valid(40, lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h in_ready=%b expected 1/%h/0", i, out_valid, out_data, in_ready, e);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_still_valid: got %b expected 1", out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [7:0] e;
    logic [7:0] e2;
    in_valid = 1'b1;
    in_data  = 8'h21;
    exp_q.push_back(~8'h21 + 8'd1);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_data = 8'($urandom);
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
      @(posedge clk); #1;
      lat++;
    end
    in_data = 8'h33;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      n_errors++; $display("FAIL busy_first: got %h valid=%b expected %h", out_data, out_valid, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL busy_idle: got %b expected 1", in_ready); end
    exp_q.push_back(~8'h33 + 8'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL busy_second_accept: got %b expected 0", in_ready); end
    wait_valid(40, lat);
    e2 = exp_q.pop_front();
    n_checks++;
    if (lat !== 8 || out_data !== e2) begin
      n_errors++; $display("FAIL busy_second: got %h lat %0d expected %h lat 8", out_data, lat, e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [7:0] e;
    issue(8'h5A);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset: got valid=%b data=%h in_ready=%b expected 0/00/1", out_valid, out_data, in_ready);
    end
    lat = 0;
    repeat (10) begin
      if (out_valid) lat++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat !== 0) begin n_errors++; $display("FAIL midreset_no_result: got %0d valid cycles expected 0", lat); end
    issue(8'h10);
    wait_valid(40, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== 8 || out_data !== e || e !== 8'hF0) begin
      n_errors++; $display("FAIL midreset_new: got %h lat %0d expected %h lat 8", out_data, lat, e);
    end
    @(posedge clk); #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 16 : 33);
    logic         s_rst;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [W-1:0] s_in_data;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [W-1:0] s_out_data;
    logic         s_ovf;
    logic [W-1:0] sq[$];
    bit           done = 0;

    serial_twos_complementer #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data)
`ifdef TWOS_COMP_OVF_EN
      ,
      .ovf       (s_ovf)
`endif
    );

`ifndef TWOS_COMP_OVF_EN
    assign s_ovf = 1'b0;
`endif

    task automatic run_sweep();
      int n;
      int lat;
      logic [63:0]  r;
      logic [W-1:0] x;
      logic [W-1:0] e;
      logic [W-1:0] msb;
      msb = '0;
      msb[W-1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      s_rst = 1'b0;
      n = (W == 2) ? 4 : 1000;
      for (int i = 0; i < n; i++) begin
        r = {$urandom, $urandom};
        if (W == 2)      x = i[W-1:0];
        else if (i == 0) x = '0;
        else if (i == 1) x = msb;
        else             x = r[W-1:0];
        e = ~x + 1'b1;
        sq.push_back(e);
        s_in_valid = 1'b1;
        s_in_data  = x;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < W + 20) begin
          @(posedge clk); #1;
          lat++;
        end
        e = sq.pop_front();
        n_checks++;
        if (lat !== W || s_out_data !== e) begin
          n_errors++;
          $display("FAIL sweep_w%0d: in %h got %h lat %0d expected %h lat %0d", W, x, s_out_data, lat, e, W);
        end
`ifdef TWOS_COMP_OVF_EN
        n_checks++;
        if (s_ovf !== (x == msb)) begin n_errors++; $display("FAIL sweep_ovf_w%0d: in %h got %b", W, x, s_ovf); end
`endif
        @(posedge clk); #1;
      end
    endtask

    initial begin
      s_rst = 1'b1;
      s_in_valid = 1'b0;
      s_in_data = '0;
      s_out_ready = 1'b1;
      wait (sweep_start);
      run_sweep();
      done = 1'b1;
    end
  end

  task automatic test_width_sweep();
    int t;
    sweep_start = 1'b1;
    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_checks++;
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) begin
      n_errors++; $display("FAIL sweep_timeout: got %0d cycles without completion expected completion", t);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_edge_values();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_width_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
